fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue.sv | 126 ++++++++++++
 tb/tb_fetch_queue.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction fetch queue: a circular buffer of {pc, instr} entries that feeds
// one decode register, with stall hold, kill flush and a saturating flush counter.
module fetch_queue #(
  parameter int          DEPTH = 4,
  parameter logic [31:0] NOP   = 32'h00000013
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic                       push_valid,
  input  logic [31:0]                push_pc,
  input  logic [31:0]                push_instr,
  output logic                       push_ready,
  input  logic                       stall,
  input  logic                       kill,
  output logic                       dec_valid,
  output logic [31:0]                dec_pc,
  output logic [31:0]                dec_instr,
  output logic [6:0]                 dec_op_code,
  output logic [4:0]                 dec_rd,
  output logic [4:0]                 dec_rs1,
  output logic [4:0]                 dec_rs2,
  output logic [$clog2(DEPTH):0]     count,
  output logic [7:0]                 flush_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   pc_mem_q    [DEPTH];
  logic [31:0]   instr_mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          dec_valid_q, dec_valid_d;
  logic [31:0]   dec_pc_q, dec_pc_d;
  logic [31:0]   dec_instr_q, dec_instr_d;
  logic [7:0]    flush_cnt_q, flush_cnt_d;

  logic          do_push;
  logic          do_pop;

  // Ready depends only on stored count, never on a same-cycle pop.
  assign push_ready = nrst && (count_q < CW'(DEPTH)) && !kill;
  assign do_push    = push_valid && push_ready;
  assign do_pop     = !kill && !stall && (count_q != '0);

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    dec_valid_d = dec_valid_q;
    dec_pc_d    = dec_pc_q;
    dec_instr_d = dec_instr_q;
    flush_cnt_d = flush_cnt_q;

    if (kill) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      dec_valid_d = 1'b0;
      dec_instr_d = NOP;
      if (flush_cnt_q != 8'hFF) flush_cnt_d = flush_cnt_q + 8'd1;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);

      if (!stall) begin
        if (do_pop) begin
          dec_valid_d = 1'b1;
          dec_pc_d    = pc_mem_q[rd_ptr_q];
          dec_instr_d = instr_mem_q[rd_ptr_q];
          rd_ptr_d    = rd_ptr_q + AW'(1);
        end else begin
          // Empty queue: present a bubble; dec_pc keeps the last real PC.
          dec_valid_d = 1'b0;
          dec_instr_d = NOP;
        end
      end

      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      dec_valid_q <= 1'b0;
      dec_pc_q    <= '0;
      dec_instr_q <= NOP;
      flush_cnt_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      dec_valid_q <= dec_valid_d;
      dec_pc_q    <= dec_pc_d;
      dec_instr_q <= dec_instr_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) begin
      pc_mem_q[wr_ptr_q]    <= push_pc;
      instr_mem_q[wr_ptr_q] <= push_instr;
    end
  end

  assign dec_valid   = dec_valid_q;
  assign dec_pc      = dec_pc_q;
  assign dec_instr   = dec_instr_q;
  assign dec_op_code = dec_instr_q[6:0];
  assign dec_rd      = dec_instr_q[11:7];
  assign dec_rs1     = dec_instr_q[19:15];
  assign dec_rs2     = dec_instr_q[24:20];
  assign count       = count_q;
  assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Testbench for fetch_queue: randomized traffic compared against a queue-based
// reference model of the decode register, count and flush counter.
module tb_fetch_queue;
  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        push_valid = 1'b0;
  logic [31:0] push_pc = '0;
  logic [31:0] push_instr = '0;
  logic        push_ready;
  logic        stall = 1'b0;
  logic        kill = 1'b0;
  logic        dec_valid;
  logic [31:0] dec_pc;
  logic [31:0] dec_instr;
  logic [6:0]  dec_op_code;
  logic [4:0]  dec_rd, dec_rs1, dec_rs2;
  logic [2:0]  count;
  logic [7:0]  flush_cnt;

  int checks = 0;
  int errors = 0;

  fetch_queue #(.DEPTH(DEPTH), .NOP(NOP)) dut (
    .clk(clk), .nrst(nrst),
    .push_valid(push_valid), .push_pc(push_pc), .push_instr(push_instr),
    .push_ready(push_ready), .stall(stall), .kill(kill),
    .dec_valid(dec_valid), .dec_pc(dec_pc), .dec_instr(dec_instr),
    .dec_op_code(dec_op_code), .dec_rd(dec_rd), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .count(count), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: a FIFO of entries plus the decode register contents.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        m_q[$];
  logic        m_dv = 1'b0;
  logic [31:0] m_pc = '0;
  logic [31:0] m_instr = NOP;
  int          m_fl = 0;
  bit          m_acc = 1'b0;

  function automatic logic [75:0] m_vec();
    return {m_dv, m_pc, m_instr, 3'(m_q.size()), 8'(m_fl)};
  endfunction

  function automatic logic m_ready();
    return nrst && (m_q.size() < DEPTH) && !kill;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_dv = 1'b0;
    m_pc = '0;
    m_instr = NOP;
    m_fl = 0;
  endtask

  // Advance the model by one clock edge using the currently driven inputs,
  // then let the DUT take the same edge.
  task automatic cycle();
    ent_t e;
    bit   rdy;
    m_acc = 1'b0;
    if (!nrst) begin
      model_reset();
    end else if (kill) begin
      m_q.delete();
      m_dv = 1'b0;
      m_instr = NOP;
      if (m_fl < 255) m_fl++;
    end else begin
      rdy = (m_q.size() < DEPTH);
      if (!stall) begin
        if (m_q.size() > 0) begin
          e = m_q.pop_front();
          m_dv = 1'b1;
          m_pc = e.pc;
          m_instr = e.instr;
        end else begin
          m_dv = 1'b0;
          m_instr = NOP;
        end
      end
      if (push_valid && rdy) begin
        e.pc = push_pc;
        e.instr = push_instr;
        m_q.push_back(e);
        m_acc = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    push_valid = 1'b0;
    stall = 1'b0;
    kill = 1'b0;
    repeat (DEPTH + 2) cycle();
  endtask

  function automatic logic [75:0] dut_vec();
    return {dec_valid, dec_pc, dec_instr, count, flush_cnt};
  endfunction

  task automatic test_reset();
    nrst = 1'b0;
    push_valid = 1'b1;
    push_pc = 32'h40;
    push_instr = 32'h00500093;
    model_reset();
    #7;
    checks++;
    if (dut_vec() !== m_vec()) begin
      errors++;
      $display("FAIL reset_state got %h exp %h", dut_vec(), m_vec());
    end
    checks++;
    if (push_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready got %b exp 0", push_ready);
    end
    @(posedge clk);
    #1;
    push_valid = 1'b0;
    nrst = 1'b1;
    cycle();
    checks++;
    if (dut_vec() !== m_vec()) begin
      errors++;
      $display("FAIL reset_release got %h exp %h", dut_vec(), m_vec());
    end
  endtask

  task automatic test_in_order();
    logic [21:0] fexp;
    for (int i = 0; i < 7; i++) begin
      push_valid = (i < 4);
      push_pc = 32'h100 + 32'(4 * i);
      push_instr = $urandom;
      #1;
      checks++;
      if (push_ready !== m_ready()) begin
        errors++;
        $display("FAIL order_ready[%0d] got %b exp %b", i, push_ready, m_ready());
      end
      cycle();
      checks++;
      if (dut_vec() !== m_vec()) begin
        errors++;
        $display("FAIL order_dec[%0d] got %h exp %h", i, dut_vec(), m_vec());
      end
      fexp = {m_instr[6:0], m_instr[11:7], m_instr[19:15], m_instr[24:20]};
      checks++;
      if ({dec_op_code, dec_rd, dec_rs1, dec_rs2} !== fexp) begin
        errors++;
        $display("FAIL order_fields[%0d] got %h exp %h", i,
                 {dec_op_code, dec_rd, dec_rs1, dec_rs2}, fexp);
      end
    end
    checks++;
    if ({dec_valid, dec_pc, dec_op_code, dec_rd, dec_rs1, dec_rs2} !== {1'b0, 32'h10C, 7'b0010011, 15'd0}) begin
      errors++;
      $display("FAIL order_bubble got %b %h %b %h %h %h exp 0 10c 0010011 0 0 0",
               dec_valid, dec_pc, dec_op_code, dec_rd, dec_rs1, dec_rs2);
    end
  endtask

  task automatic test_stall_full();
    int budget;
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push_valid = 1'b1;
      push_pc = 32'h300 + 32'(4 * i);
      push_instr = $urandom;
      cycle();
      checks++;
      if (dut_vec() !== m_vec()) begin
        errors++;
        $display("FAIL stall_fill[%0d] got %h exp %h", i, dut_vec(), m_vec());
      end
    end
    push_pc = 32'h310;
    push_instr = $urandom;
    #1;
    checks++;
    if ({push_ready, count} !== {m_ready(), 3'(m_q.size())}) begin
      errors++;
      $display("FAIL stall_full got rdy=%b cnt=%0d exp rdy=%b cnt=%0d",
               push_ready, count, m_ready(), m_q.size());
    end
    cycle();
    stall = 1'b0;
    budget = 0;
    while (m_q.size() > 0 || push_valid) begin
      cycle();
      checks++;
      if (dut_vec() !== m_vec()) begin
        errors++;
        $display("FAIL stall_drain[%0d] got %h exp %h", budget, dut_vec(), m_vec());
      end
      if (m_acc) push_valid = 1'b0;
      budget++;
      if (budget > 20) begin
        errors++;
        $display("FAIL stall_drain_timeout got %0d cycles exp <=20", budget);
        break;
      end
    end
  endtask

  task automatic test_kill_push();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push_valid = 1'b1;
      push_pc = 32'h500 + 32'(4 * i);
      push_instr = $urandom;
      cycle();
    end
    push_pc = 32'h50C;
    kill = 1'b1;
    #1;
    checks++;
    if (push_ready !== 1'b0) begin
      errors++;
      $display("FAIL kill_ready got %b exp 0", push_ready);
    end
    cycle();
    kill = 1'b0;
    push_valid = 1'b0;
    stall = 1'b0;
    checks++;
    if (dut_vec() !== m_vec()) begin
      errors++;
      $display("FAIL kill_push got %h exp %h", dut_vec(), m_vec());
    end
    checks++;
    if ({count, dec_valid, dec_instr} !== {3'd0, 1'b0, 32'h00000013}) begin
      errors++;
      $display("FAIL kill_push_const got cnt=%0d v=%b i=%h exp 0 0 00000013",
               count, dec_valid, dec_instr);
    end
    cycle();
    checks++;
    if (dut_vec() !== m_vec()) begin
      errors++;
      $display("FAIL kill_push_after got %h exp %h", dut_vec(), m_vec());
    end
  endtask

  task automatic test_kill_stall();
    push_valid = 1'b1;
    push_pc = 32'h600;
    push_instr = $urandom;
    cycle();
    push_pc = 32'h604;
    cycle();
    push_valid = 1'b0;
    stall = 1'b1;
    kill = 1'b1;
    cycle();
    kill = 1'b0;
    stall = 1'b0;
    checks++;
    if (dut_vec() !== m_vec()) begin
      errors++;
      $display("FAIL kill_stall got %h exp %h", dut_vec(), m_vec());
    end
  endtask

  task automatic test_random_stream();
    int pushed = 0;
    int cyc = 0;
    push_valid = 1'b1;
    push_pc = 32'h1000;
    push_instr = $urandom;
    while ((pushed < 12 || m_q.size() > 0 || m_dv) && cyc < 200) begin
      stall = ($urandom_range(0, 2) == 0);
      cycle();
      checks++;
      if (dut_vec() !== m_vec()) begin
        errors++;
        $display("FAIL stream[%0d] got %h exp %h", cyc, dut_vec(), m_vec());
      end
      if (m_acc) begin
        pushed++;
        push_pc = push_pc + 32'd4;
        push_instr = $urandom;
        push_valid = (pushed < 12);
      end
      cyc++;
    end
    stall = 1'b0;
    push_valid = 1'b0;
    if (cyc >= 200) begin
      checks++;
      errors++;
      $display("FAIL stream_timeout got %0d cycles exp <200", cyc);
    end
  endtask

  task automatic test_flush_reset();
    kill = 1'b1;
    repeat (300) cycle();
    kill = 1'b0;
    checks++;
    if (flush_cnt !== 8'(m_fl) || flush_cnt !== 8'hFF) begin
      errors++;
      $display("FAIL flush_sat got %0d exp 255", flush_cnt);
    end
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push_valid = 1'b1;
      push_pc = 32'h700 + 32'(4 * i);
      push_instr = $urandom;
      cycle();
    end
    stall = 1'b0;
    cycle();
    #2;
    nrst = 1'b0;
    model_reset();
    #1;
    checks++;
    if (dut_vec() !== m_vec() || push_ready !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got %h rdy=%b exp %h rdy=0", dut_vec(), push_ready, m_vec());
    end
    cycle();
    cycle();
    nrst = 1'b1;
    push_valid = 1'b1;
    push_pc = 32'h200;
    push_instr = 32'h00A00113;
    cycle();
    push_valid = 1'b0;
    cycle();
    checks++;
    if (dut_vec() !== m_vec()) begin
      errors++;
      $display("FAIL post_reset got %h exp %h", dut_vec(), m_vec());
    end
  endtask

  initial begin
    test_reset();
    test_in_order();
    drain();
    test_stall_full();
    drain();
    test_kill_push();
    test_kill_stall();
    test_random_stream();
    drain();
    test_flush_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
